// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared IFU constants and state encodings
// Widths and reset PC are shared with the instruction memory.
package instr_fetch_unit_pkg;

  localparam int IFU_ADDR_W = 32;
  localparam int IFU_DATA_W = 32;
  localparam logic [IFU_ADDR_W-1:0] IFU_RESET_PC = '0;
  localparam int IFU_PERF_W = 32;

  typedef enum logic [1:0] {
    ST_FILL     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STALL    = 2'd2,
    ST_REDIRECT = 2'd3
  } ifu_state_t;

  // A response word is held only in RUN/STALL; FILL and REDIRECT are bubbles.
  function automatic logic ifu_state_has_word(input ifu_state_t st);
    return (st == ST_RUN) || (st == ST_STALL);
  endfunction

  function automatic logic ifu_state_is_bubble(input ifu_state_t st);
    return (st == ST_FILL) || (st == ST_REDIRECT);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_perf_counters.sv
// rtl/instr_fetch_unit_perf_counters.sv - free-running IFU event counters
// Three independent 32-bit counters that wrap and are never frozen.
module ifu_perf_counters
  import instr_fetch_unit_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetched_inc,
  input  logic                  stall_inc,
  input  logic                  bubble_inc,
  output logic [IFU_PERF_W-1:0] perf_fetched,
  output logic [IFU_PERF_W-1:0] perf_stall,
  output logic [IFU_PERF_W-1:0] perf_bubble
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
      perf_bubble  <= '0;
    end else begin
      if (fetched_inc) perf_fetched <= perf_fetched + 1'b1;
      if (stall_inc)   perf_stall   <= perf_stall + 1'b1;
      if (bubble_inc)  perf_bubble  <= perf_bubble + 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - IF stage: PC, imem addressing, decode handshake, redirects
// Optional IFU_PERF_CNT_EN adds perf_fetched/perf_stall/perf_bubble outputs.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = IFU_ADDR_W,
  parameter int                DATA_W   = IFU_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFU_RESET_PC),
  parameter int                PC_STEP  = 1
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_address,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              instr_ready,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [IFU_PERF_W-1:0] perf_fetched,
  output logic [IFU_PERF_W-1:0] perf_stall,
  output logic [IFU_PERF_W-1:0] perf_bubble
`endif
);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  ifu_state_t        state;
  logic              resp_valid;
  logic              stall;

  // resp_valid is fully determined by the registered state, so it is decoded rather than stored twice.
  assign resp_valid = ifu_state_has_word(state);
  assign stall      = resp_valid & ~instr_ready;

  // While stalled, re-read the held word so the ROM output stays stable.
  assign imem_address = stall ? resp_pc : fetch_pc;

  assign instr       = imem_data;
  assign instr_pc    = resp_pc;
  assign instr_valid = resp_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= '0;
      state    <= ST_FILL;
    end else if (branch_taken) begin
      fetch_pc <= branch_target;
      state    <= ST_REDIRECT;
    end else if (stall) begin
      state    <= ST_STALL;
    end else begin
      resp_pc  <= fetch_pc;
      fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
      state    <= ST_RUN;
    end
  end

`ifdef IFU_PERF_CNT_EN
  ifu_perf_counters u_perf (
    .clock        (clock),
    .reset        (reset),
    .fetched_inc  (resp_valid & instr_ready),
    .stall_inc    (stall),
    .bubble_inc   (ifu_state_is_bubble(state)),
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall),
    .perf_bubble  (perf_bubble)
  );
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
// Two DUTs share one reset: RESET_PC=0 for the main flow, RESET_PC=FFFFFFFE for wrap.
module tb_instr_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        instr_ready;

  logic [31:0] addr0, data0, instr0, pc0;
  logic        valid0;
  logic [31:0] addr1, data1, instr1, pc1;
  logic        valid1;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] pf0, ps0, pb0, pf1, ps1, pb1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  // Behavioural 1-cycle ROMs: mem[i] = A000_0000 + i
  always @(posedge clock) data0 <= 32'hA000_0000 + addr0;
  always @(posedge clock) data1 <= 32'hA000_0000 + addr1;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (
    .clock         (clock),
    .reset         (reset),
    .imem_address  (addr0),
    .imem_data     (data0),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr_ready   (instr_ready),
    .instr_valid   (valid0),
    .instr         (instr0),
    .instr_pc      (pc0)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetched  (pf0),
    .perf_stall    (ps0),
    .perf_bubble   (pb0)
`endif
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFE)) dut1 (
    .clock         (clock),
    .reset         (reset),
    .imem_address  (addr1),
    .imem_data     (data1),
    .branch_taken  (1'b0),
    .branch_target (32'h0),
    .instr_ready   (1'b1),
    .instr_valid   (valid1),
    .instr         (instr1),
    .instr_pc      (pc1)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetched  (pf1),
    .perf_stall    (ps1),
    .perf_bubble   (pb1)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_word(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, valid0, 1'b1);
    check({tag, "_pc"}, pc0, pc);
    check({tag, "_instr"}, instr0, 32'hA000_0000 + pc);
  endtask

  initial begin
    reset         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    instr_ready   = 1'b1;
    tick();
    tick();

    check("rst_valid", valid0, 1'b0);
    check("rst_pc", pc0, 32'h0);
    check("rst_addr", addr0, 32'h0);
    check("rst_addr_wrapdut", addr1, 32'hFFFF_FFFE);
`ifdef IFU_PERF_CNT_EN
    check("rst_perf_fetched", pf0, 32'd0);
`endif

    // Streaming from reset, plus wrap on the second DUT
    reset = 1'b1;
    tick();
    expect_word("run0", 32'd0);
    check("wrap0_pc", pc1, 32'hFFFF_FFFE);
    tick();
    expect_word("run1", 32'd1);
    check("wrap1_pc", pc1, 32'hFFFF_FFFF);
    tick();
    expect_word("run2", 32'd2);
    check("wrap2_pc", pc1, 32'h0000_0000);
    check("wrap2_instr", instr1, 32'hA000_0000);

    // Stall 3 cycles at pc=2
    instr_ready = 1'b0;
    #1;
    check("stall_addr", addr0, 32'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_word("stall", 32'd2);
      check("stall_addr_hold", addr0, 32'd2);
    end
    instr_ready = 1'b1;
    #1;
    check("release_addr", addr0, 32'd3);
    tick();
    expect_word("release3", 32'd3);
    tick();
    expect_word("run4", 32'd4);
    tick();
    expect_word("run5", 32'd5);

    // Redirect at pc=5 with word 5 accepted the same cycle
    branch_taken  = 1'b1;
    branch_target = 32'h10;
    tick();
    branch_taken = 1'b0;
    check("redir_bubble", valid0, 1'b0);
    tick();
    expect_word("redir_tgt", 32'h10);

    branch_taken  = 1'b1;
    branch_target = 32'h6;
    tick();
    branch_taken = 1'b0;
    check("redir2_bubble", valid0, 1'b0);
    tick();
    expect_word("redir2_tgt", 32'h6);
    tick();
    expect_word("run7", 32'h7);

    // Redirect while stalled on pc=7: word 7 is dropped
    instr_ready = 1'b0;
    tick();
    expect_word("stall7", 32'h7);
    branch_taken  = 1'b1;
    branch_target = 32'h20;
    tick();
    branch_taken = 1'b0;
    instr_ready  = 1'b1;
    check("stallbr_bubble", valid0, 1'b0);
    tick();
    expect_word("stallbr_tgt", 32'h20);
    tick();
    expect_word("stallbr_next", 32'h21);
`ifdef IFU_PERF_CNT_EN
    check("perf_stall", ps0, 32'd5);
    check("perf_bubble", pb0, 32'd4);
`endif

    // Asynchronous reset mid-stream
    reset = 1'b0;
    #1;
    check("mid_rst_valid", valid0, 1'b0);
    check("mid_rst_addr", addr0, 32'h0);
`ifdef IFU_PERF_CNT_EN
    check("mid_rst_pf", pf0, 32'd0);
    check("mid_rst_ps", ps0, 32'd0);
    check("mid_rst_pb", pb0, 32'd0);
`endif
    tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    expect_word("post_rst", 32'd4);
`ifdef IFU_PERF_CNT_EN
    check("post_rst_pf", pf0, 32'd4);
    check("post_rst_pb", pb0, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
